// File: rtl/key_pkg.sv
// Shared types and helpers for the debounced key bank.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } key_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_channel.sv
// One key: two-flop synchronizer, debounce FSM, registered press/release pulses
// and an auto-repeat timer.
module key_channel
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic clock,
  input  logic reset,
  input  logic key_in,
  input  logic repeat_en,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse,
  output logic held
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RW = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic          sync1, sync2, pressed;
  key_state_t    state, state_next;
  logic [DW-1:0] db_cnt, db_cnt_next;
  logic [RW-1:0] rpt_cnt, rpt_cnt_next;
  logic          first_done, first_done_next;
  logic          press_next, release_next, repeat_next;

  // Synchronizer resets to the raw released level so no false press follows reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= ACTIVE_LOW;
      sync2 <= ACTIVE_LOW;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
    end
  end

  assign pressed = sync2 ^ ACTIVE_LOW;

  always_comb begin
    state_next   = state;
    db_cnt_next  = db_cnt;
    press_next   = 1'b0;
    release_next = 1'b0;
    case (state)
      IDLE: begin
        if (pressed) begin
          state_next  = PRESS_DB;
          db_cnt_next = '0;
        end
      end
      PRESS_DB: begin
        if (!pressed) begin
          state_next = IDLE;
        end else if (db_cnt == DB_LAST) begin
          state_next = HELD;
          press_next = 1'b1;
        end else begin
          db_cnt_next = db_cnt + DW'(1);
        end
      end
      HELD: begin
        if (!pressed) begin
          state_next  = RELEASE_DB;
          db_cnt_next = '0;
        end
      end
      RELEASE_DB: begin
        if (pressed) begin
          state_next = HELD;
        end else if (db_cnt == DB_LAST) begin
          state_next   = IDLE;
          release_next = 1'b1;
        end else begin
          db_cnt_next = db_cnt + DW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Repeat timer only advances in HELD; it freezes through RELEASE_DB so a
  // release glitch does not restart the repeat cadence.
  always_comb begin
    rpt_cnt_next    = rpt_cnt;
    first_done_next = first_done;
    repeat_next     = 1'b0;
    if (!repeat_en || press_next) begin
      rpt_cnt_next    = '0;
      first_done_next = 1'b0;
    end else if (state == HELD) begin
      if (rpt_cnt == (first_done ? PERIOD_LAST : DELAY_LAST)) begin
        rpt_cnt_next    = '0;
        first_done_next = 1'b1;
        repeat_next     = 1'b1;
      end else begin
        rpt_cnt_next = rpt_cnt + RW'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      db_cnt        <= '0;
      rpt_cnt       <= '0;
      first_done    <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      state         <= state_next;
      db_cnt        <= db_cnt_next;
      rpt_cnt       <= rpt_cnt_next;
      first_done    <= first_done_next;
      press_pulse   <= press_next;
      release_pulse <= release_next;
      repeat_pulse  <= repeat_next;
    end
  end

  assign held = (state == HELD) || (state == RELEASE_DB);

endmodule

// File: rtl/key_pulse_bank.sv
// Bank of NUM_KEYS independent debounced key channels.
module key_pulse_bank
  import key_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_in,
  input  logic [NUM_KEYS-1:0] repeat_en,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse,
  output logic [NUM_KEYS-1:0] repeat_pulse,
  output logic [NUM_KEYS-1:0] held
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_channel (
      .clock        (clock),
      .reset        (reset),
      .key_in       (key_in[i]),
      .repeat_en    (repeat_en[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .repeat_pulse (repeat_pulse[i]),
      .held         (held[i])
    );
  end

endmodule

// File: tb/tb_key_pulse_bank.sv
// Directed bench for key_pulse_bank with a run-length/deadline reference model.
module tb_key_pulse_bank;

  localparam int NK = 4;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic [NK-1:0] key_in, repeat_en;
  logic [NK-1:0] press_pulse, release_pulse, repeat_pulse, held;

  key_pulse_bank #(
    .NUM_KEYS       (NK),
    .DEBOUNCE_CYCLES(DB),
    .ACTIVE_LOW     (1'b1),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .key_in       (key_in),
    .repeat_en    (repeat_en),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .repeat_pulse (repeat_pulse),
    .held         (held)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Model: a key is accepted once its synchronized level has differed from the
  // accepted level for DB+1 consecutive edges; repeats fire on deadlines.
  int            cyc = 0;
  logic [NK-1:0] m_s1 = '1, m_s2 = '1;
  int            run[NK];
  bit            acc[NK];
  int            due[NK];
  logic [NK-1:0] e_press = '0, e_rel = '0, e_rpt = '0, e_held = '0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_s1 = '1;
      m_s2 = '1;
      for (int ch = 0; ch < NK; ch++) begin
        run[ch] = 0;
        acc[ch] = 1'b0;
        due[ch] = 0;
      end
      e_press = '0; e_rel = '0; e_rpt = '0; e_held = '0;
    end else begin
      cyc = cyc + 1;
      for (int ch = 0; ch < NK; ch++) begin
        bit lvl, was_held, was_rel;
        lvl      = ~m_s2[ch];
        was_held = acc[ch] && run[ch] == 0;
        was_rel  = acc[ch] && run[ch] > 0;
        e_press[ch] = 1'b0;
        e_rel[ch]   = 1'b0;
        e_rpt[ch]   = 1'b0;
        if (!repeat_en[ch]) due[ch] = cyc + RD;
        else if (was_held) begin
          if (cyc == due[ch]) begin
            e_rpt[ch] = 1'b1;
            due[ch]   = cyc + RP;
          end
        end else if (was_rel) due[ch] = due[ch] + 1;
        if (lvl != acc[ch]) run[ch] = run[ch] + 1;
        else run[ch] = 0;
        if (run[ch] == DB + 1) begin
          if (!acc[ch]) begin
            e_press[ch] = 1'b1;
            due[ch]     = cyc + RD;
          end else e_rel[ch] = 1'b1;
          acc[ch] = !acc[ch];
          run[ch] = 0;
        end
        e_held[ch] = acc[ch];
      end
      m_s2 = m_s1;
      m_s1 = key_in;
    end
  end

  always @(negedge clock) begin
    checks = checks + 4;
    if (press_pulse !== e_press) begin
      errors = errors + 1;
      $display("FAIL model_press cyc=%0d got=%h exp=%h", cyc, press_pulse, e_press);
    end
    if (release_pulse !== e_rel) begin
      errors = errors + 1;
      $display("FAIL model_release cyc=%0d got=%h exp=%h", cyc, release_pulse, e_rel);
    end
    if (repeat_pulse !== e_rpt) begin
      errors = errors + 1;
      $display("FAIL model_repeat cyc=%0d got=%h exp=%h", cyc, repeat_pulse, e_rpt);
    end
    if (held !== e_held) begin
      errors = errors + 1;
      $display("FAIL model_held cyc=%0d got=%h exp=%h", cyc, held, e_held);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  // kind: 0 press, 1 release, 2 repeat. Returns the edge index or -1 on timeout.
  task automatic wait_pulse(input string name, input int kind, input int ch, output int at);
    at = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if ((kind == 0 && press_pulse[ch]) || (kind == 1 && release_pulse[ch]) ||
          (kind == 2 && repeat_pulse[ch])) begin
        at = cyc;
        return;
      end
    end
    checks = checks + 1;
    errors = errors + 1;
    $display("FAIL %s_timeout got=none exp=pulse", name);
  endtask

  task automatic count_pulses(input int kind, input int ch, input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if ((kind == 0 && press_pulse[ch]) || (kind == 1 && release_pulse[ch]) ||
          (kind == 2 && repeat_pulse[ch])) cnt = cnt + 1;
    end
  endtask

  initial begin
    int k, at, p, cnt;
    reset     = 1'b1;
    key_in    = '1;
    repeat_en = '0;
    repeat (2) @(negedge clock);
    check("reset_outputs", int'({press_pulse, release_pulse, repeat_pulse, held}), 0);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    // Single press latency and held.
    key_in[0] = 1'b0;
    k = cyc + 1;
    wait_pulse("press0", 0, 0, at);
    check("press0_latency", at, k + 6);
    check("held0_on_press", int'(held[0]), 1);

    // Short bounce never accepted.
    @(negedge clock);
    key_in[1] = 1'b0;
    repeat (3) @(negedge clock);
    key_in[1] = 1'b1;
    count_pulses(0, 1, 12, cnt);
    check("bounce1_no_press", cnt, 0);
    check("bounce1_not_held", int'(held[1]), 0);

    // Auto-repeat cadence and disable.
    repeat_en[2] = 1'b1;
    key_in[2]    = 1'b0;
    wait_pulse("press2", 0, 2, p);
    wait_pulse("rpt2_first", 2, 2, at);
    check("rpt2_first_delay", at, p + 10);
    wait_pulse("rpt2_second", 2, 2, at);
    check("rpt2_second", at, p + 13);
    wait_pulse("rpt2_third", 2, 2, at);
    check("rpt2_third", at, p + 16);
    repeat_en[2] = 1'b0;
    count_pulses(2, 2, 12, cnt);
    check("rpt2_disabled", cnt, 0);

    // Release glitch ignored, then true release latency.
    key_in[3] = 1'b0;
    wait_pulse("press3", 0, 3, at);
    @(negedge clock);
    key_in[3] = 1'b1;
    repeat (2) @(negedge clock);
    key_in[3] = 1'b0;
    count_pulses(1, 3, 10, cnt);
    check("glitch3_no_release", cnt, 0);
    check("glitch3_held", int'(held[3]), 1);
    key_in[3] = 1'b1;
    k = cyc + 1;
    wait_pulse("release3", 1, 3, at);
    check("release3_latency", at, k + 6);

    // Async reset while held, then re-debounce.
    @(negedge clock);
    #2 reset = 1'b1;
    #1 check("async_reset_outputs", int'({press_pulse, release_pulse, repeat_pulse, held}), 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    k = cyc + 1;
    wait_pulse("press0_after_reset", 0, 0, at);
    check("press0_after_reset", at, k + 6);

    // Simultaneous press on all keys.
    key_in = '1;
    repeat (20) @(negedge clock);
    key_in = '0;
    wait_pulse("press_all", 0, 0, at);
    check("press_all_same_cycle", int'(press_pulse), 15);
    repeat (5) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
